systolic_feeder: RTL and testbench

- Edge driver for the N x N int8 systolic matmul array: the transmitting end of the PE a/b dataflow.
- Holds operand matrices A and B in internal register buffers and, on start, pulses the array-wide clear.
- Then drives skewed, zero-padded A rows into the left-edge a_in lanes and B columns into the top-edge b_in lanes.
- Signals done on the cycle the array's C accumulators become final.

---
 rtl/systolic_pkg.sv | 18 +
 rtl/systolic_feeder_matrix_buf.sv | 38 +++
 rtl/systolic_feeder.sv | 130 +++++++++++++
 tb/tb_systolic_feeder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic array edge feeder.
package systolic_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Stream cycles needed for the last operand to reach PE(N-1,N-1): t = 0 .. 3N-3.
  function automatic int unsigned stream_len(input int unsigned n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/systolic_feeder_matrix_buf.sv
// N x N operand register file: one write port, whole-array read bus (row-major).
module matrix_buf #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [IW-1:0]     wr_row,
  input  logic [IW-1:0]     wr_col,
  input  logic [DW-1:0]     wr_data,
  output logic [N*N*DW-1:0] rd_data
);

  localparam int unsigned MW = N * N * DW;

  logic [MW-1:0] mem_q;
  logic          wr_hit;
  int unsigned   wr_idx;

  // Out-of-range indices only exist when N is not a power of two.
  always_comb begin
    wr_hit = wr_en && (32'(wr_row) < N) && (32'(wr_col) < N);
    wr_idx = (32'(wr_row) * N + 32'(wr_col)) * DW;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q <= '0;
    end else if (wr_hit) begin
      mem_q[wr_idx +: DW] <= wr_data;
    end
  end

  assign rd_data = mem_q;

endmodule

// File: rtl/systolic_feeder.sv
// Edge driver for an N x N systolic matmul array: clears the array, then streams
// skewed A rows / B columns into the left and top edges and flags completion.
module systolic_feeder
  import systolic_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = DATA_W,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [IW-1:0]   wr_row,
  input  logic [IW-1:0]   wr_col,
  input  logic [DW-1:0]   wr_data,
  input  logic            start,
  output logic [N*DW-1:0] a_lanes,
  output logic [N*DW-1:0] b_lanes,
  output logic            clear_out,
  output logic            busy,
  output logic            done
);

  localparam int unsigned LEN = stream_len(N);
  localparam int unsigned TW  = $clog2(LEN);
  localparam int unsigned MW  = N * N * DW;

  state_e          state_q;
  logic [TW-1:0]   t_q;
  logic [N*DW-1:0] a_lanes_q, b_lanes_q;
  logic            clear_q, busy_q, done_q;

  logic [MW-1:0]   a_mem, b_mem;
  logic            wr_ok;
  int unsigned     t_sel;
  logic [N*DW-1:0] a_skew_d, b_skew_d;

  assign wr_ok = wr_en && (state_q == ST_IDLE);

  matrix_buf #(.N(N), .DW(DW), .IW(IW)) u_a_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_data (a_mem)
  );

  matrix_buf #(.N(N), .DW(DW), .IW(IW)) u_b_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_ok && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_data (b_mem)
  );

  // Skewed lane values for the stream step that the next cycle will present.
  always_comb begin
    t_sel    = (state_q == ST_STREAM) ? (32'(t_q) + 32'd1) : 32'd0;
    a_skew_d = '0;
    b_skew_d = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if ((t_sel >= k) && ((t_sel - k) < N)) begin
        a_skew_d[k*DW +: DW] = a_mem[(k * N + (t_sel - k)) * DW +: DW];
        b_skew_d[k*DW +: DW] = b_mem[((t_sel - k) * N + k) * DW +: DW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      t_q       <= '0;
      a_lanes_q <= '0;
      b_lanes_q <= '0;
      clear_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      clear_q   <= 1'b0;
      done_q    <= 1'b0;
      a_lanes_q <= '0;
      b_lanes_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_CLEAR;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          state_q   <= ST_STREAM;
          t_q       <= '0;
          a_lanes_q <= a_skew_d;
          b_lanes_q <= b_skew_d;
        end
        ST_STREAM: begin
          if (t_q == TW'(LEN - 1)) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else begin
            t_q       <= t_q + TW'(1);
            a_lanes_q <= a_skew_d;
            b_lanes_q <= b_skew_d;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign a_lanes   = a_lanes_q;
  assign b_lanes   = b_lanes_q;
  assign clear_out = clear_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_systolic_feeder.sv
// Bench for systolic_feeder: drives an attached behavioural PE grid and checks lanes,
// control timing and the final C matrix against shadow operands.
module tb_systolic_feeder;

  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int IW  = 2;
  localparam int LEN = 3 * N - 2;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            wr_en = 1'b0;
  logic            wr_sel = 1'b0;
  logic [IW-1:0]   wr_row = '0;
  logic [IW-1:0]   wr_col = '0;
  logic [DW-1:0]   wr_data = '0;
  logic            start = 1'b0;
  logic [N*DW-1:0] a_lanes, b_lanes;
  logic            clear_out, busy, done;

  int checks = 0;
  int errors = 0;

  logic signed [DW-1:0] sa [N][N];
  logic signed [DW-1:0] sb [N][N];

  logic signed [DW-1:0] pa [N][N];
  logic signed [DW-1:0] pb [N][N];
  int                   pc [N][N];

  systolic_feeder #(.N(N), .DW(DW), .IW(IW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_sel    (wr_sel),
    .wr_row    (wr_row),
    .wr_col    (wr_col),
    .wr_data   (wr_data),
    .start     (start),
    .a_lanes   (a_lanes),
    .b_lanes   (b_lanes),
    .clear_out (clear_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Attached PE grid: a flows right, b flows down, c accumulates a*b each edge.
  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        logic signed [DW-1:0] ain, bin;
        if (j == 0) ain = $signed(a_lanes[i*DW +: DW]);
        else        ain = pa[i][j-1];
        if (i == 0) bin = $signed(b_lanes[j*DW +: DW]);
        else        bin = pb[i-1][j];
        if (clear_out) begin
          pa[i][j] <= '0;
          pb[i][j] <= '0;
          pc[i][j] <= 0;
        end else begin
          pa[i][j] <= ain;
          pb[i][j] <= bin;
          pc[i][j] <= pc[i][j] + int'(ain) * int'(bin);
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Row i of A enters lane i delayed by i zeros, followed by zero padding.
  function automatic logic [DW-1:0] exp_a(input int i, input int t);
    logic [DW-1:0] q[$];
    for (int k = 0; k < i; k++) q.push_back('0);
    for (int c = 0; c < N; c++) q.push_back(sa[i][c]);
    if (t < q.size()) return q[t];
    return '0;
  endfunction

  function automatic logic [DW-1:0] exp_b(input int j, input int t);
    logic [DW-1:0] q[$];
    for (int k = 0; k < j; k++) q.push_back('0);
    for (int r = 0; r < N; r++) q.push_back(sb[r][j]);
    if (t < q.size()) return q[t];
    return '0;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_busy"},  64'(busy), 64'(0));
    check({tag, "_done"},  64'(done), 64'(0));
    check({tag, "_clear"}, 64'(clear_out), 64'(0));
    check({tag, "_alane"}, 64'(a_lanes), 64'(0));
    check({tag, "_blane"}, 64'(b_lanes), 64'(0));
  endtask

  task automatic write_el(input logic sel, input int r, input int c, input logic [DW-1:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic write_all();
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        write_el(1'b0, r, c, sa[r][c]);
        write_el(1'b1, r, c, sb[r][c]);
      end
  endtask

  // One run from start; optionally a write alongside start, or abuse during STREAM.
  task automatic run(input string tag, input bit abuse, input bit co_wr,
                     input logic sel, input int r, input int c, input logic [DW-1:0] d);
    logic [N*DW-1:0] ea, eb;
    start = 1'b1;
    if (co_wr) begin
      wr_en = 1'b1; wr_sel = sel; wr_row = IW'(r); wr_col = IW'(c); wr_data = d;
      if (sel) sb[r][c] = d; else sa[r][c] = d;
    end
    @(negedge clk);
    start = 1'b0; wr_en = 1'b0;
    check({tag, "_clr_clear"}, 64'(clear_out), 64'(1));
    check({tag, "_clr_busy"},  64'(busy), 64'(1));
    check({tag, "_clr_done"},  64'(done), 64'(0));
    check({tag, "_clr_alane"}, 64'(a_lanes), 64'(0));
    check({tag, "_clr_blane"}, 64'(b_lanes), 64'(0));
    for (int t = 0; t < LEN; t++) begin
      @(negedge clk);
      start = 1'b0; wr_en = 1'b0;
      for (int k = 0; k < N; k++) begin
        ea[k*DW +: DW] = exp_a(k, t);
        eb[k*DW +: DW] = exp_b(k, t);
      end
      check($sformatf("%s_t%0d_alane", tag, t), 64'(a_lanes), 64'(ea));
      check($sformatf("%s_t%0d_blane", tag, t), 64'(b_lanes), 64'(eb));
      check($sformatf("%s_t%0d_ctl", tag, t), 64'({clear_out, busy, done}), 64'(3'b010));
      if (abuse && (t == 2)) begin
        int ar, ac;
        ar = int'($urandom_range(N - 1));
        ac = int'($urandom_range(N - 1));
        start = 1'b1; wr_en = 1'b1; wr_sel = 1'b0;
        wr_row = IW'(ar); wr_col = IW'(ac); wr_data = ~sa[ar][ac];
      end
    end
    @(negedge clk);
    check({tag, "_done_ctl"},   64'({clear_out, busy, done}), 64'(3'b011));
    check({tag, "_done_alane"}, 64'(a_lanes), 64'(0));
    check({tag, "_done_blane"}, 64'(b_lanes), 64'(0));
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        int e = 0;
        for (int k = 0; k < N; k++) e += int'(sa[i][k]) * int'(sb[k][j]);
        check($sformatf("%s_c%0d%0d", tag, i, j), 64'(pc[i][j]), 64'(e));
      end
    @(negedge clk);
    check_idle({tag, "_post"});
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    rst = 1'b0;
    @(negedge clk);
    check_idle("idle");

    // Identity A times counting B: c must equal B.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = (r == c) ? 8'sd1 : 8'sd0;
        sb[r][c] = DW'(4 * r + c + 1);
      end
    write_all();
    run("ident", 1'b0, 1'b0, 1'b0, 0, 0, '0);

    // Skew pattern with B zeroed.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = DW'(10 * r + c);
        sb[r][c] = '0;
      end
    write_all();
    run("skew", 1'b0, 1'b0, 1'b0, 0, 0, '0);

    // Signed extremes.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = -8'sd128;
        sb[r][c] = -8'sd128;
      end
    write_all();
    run("neg", 1'b0, 1'b0, 1'b0, 0, 0, '0);
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = 8'sd127;
        sb[r][c] = -8'sd1;
      end
    write_all();
    run("pos", 1'b0, 1'b0, 1'b0, 0, 0, '0);

    // Random operands, protocol abuse, write-with-start and back-to-back runs.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = DW'($urandom);
        sb[r][c] = DW'($urandom);
      end
    write_all();
    run("abuse", 1'b1, 1'b0, 1'b0, 0, 0, '0);
    run("cowr", 1'b0, 1'b1, 1'($urandom_range(1)), int'($urandom_range(N - 1)),
        int'($urandom_range(N - 1)), DW'($urandom));
    run("b2b", 1'b0, 1'b0, 1'b0, 0, 0, '0);

    for (int it = 0; it < 3; it++) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c < N; c++) begin
          sa[r][c] = DW'($urandom);
          sb[r][c] = DW'($urandom);
        end
      write_all();
      run($sformatf("rnd%0d", it), 1'b0, 1'b0, 1'b0, 0, 0, '0);
    end

    // Reset mid-stream: abort, buffers cleared, next run streams zeros.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("midrst0");
    @(negedge clk);
    rst = 1'b0;
    check_idle("midrst1");
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        sa[r][c] = '0;
        sb[r][c] = '0;
      end
    @(negedge clk);
    check_idle("midrst2");
    run("zero", 1'b0, 1'b0, 1'b0, 0, 0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
